// File: rtl/palabras_pkg.sv
// Shared types and defaults for the UART word-framing controller.
`default_nettype none

package palabras_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CARGA = 1'b1
  } estado_t;

  localparam logic [7:0] SYNC_DEF    = 8'hA5;
  localparam int         TIMEOUT_DEF = 1000;

  // Timer must be able to hold the full timeout value.
  function automatic int ancho_timer(input int ciclos);
    return $clog2(ciclos + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_palabras.sv
// Two-entry word FIFO. The head register stays put when the FIFO drains,
// so dato_out keeps the last word delivered.
`default_nettype none

module fifo_palabras #(
  parameter int ANCHO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ANCHO-1:0] dato_in,
  input  logic             pop,
  output logic [ANCHO-1:0] dato_out,
  output logic             vacio,
  output logic             lleno
);

  logic [ANCHO-1:0] cab_q, cab_d;
  logic [ANCHO-1:0] col_q, col_d;
  logic [1:0]       n_q, n_d;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    cab_d   = cab_q;
    col_d   = col_q;
    n_d     = n_q;
    pop_ok  = pop && (n_q != 2'd0);
    push_ok = push && ((n_q != 2'd2) || pop_ok);

    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (n_q == 2'd0) cab_d = dato_in;
        else             col_d = dato_in;
        n_d = n_q + 2'd1;
      end
      2'b01: begin
        if (n_q == 2'd2) cab_d = col_q;
        n_d = n_q - 2'd1;
      end
      2'b11: begin
        if (n_q == 2'd1) begin
          cab_d = dato_in;
        end else begin
          cab_d = col_q;
          col_d = dato_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cab_q <= '0;
      col_q <= '0;
      n_q   <= 2'd0;
    end else begin
      cab_q <= cab_d;
      col_q <= col_d;
      n_q   <= n_d;
    end
  end

  assign dato_out = cab_q;
  assign vacio    = (n_q == 2'd0);
  assign lleno    = (n_q == 2'd2);

endmodule

`default_nettype wire

// File: rtl/control_palabras.sv
// UART receive framing: waits for a sync byte, assembles PALABRAS bytes
// little-endian into one word and queues it for the accelerator core.
`default_nettype none

module control_palabras
  import palabras_pkg::*;
#(
  parameter int         PALABRAS       = 8,
  parameter int         TIMEOUT_CICLOS = TIMEOUT_DEF,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            dato,
  input  logic                  rx_flat,
  output logic [PALABRAS*8-1:0] palabra,
  output logic                  palabra_valid,
  input  logic                  palabra_ready,
  output logic                  ocupado,
  output logic                  err_timeout,
  output logic                  err_overflow,
  output logic [15:0]           cnt_tramas
);

  localparam int AW    = PALABRAS * 8;
  localparam int IDX_W = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
  localparam int TW    = ancho_timer(TIMEOUT_CICLOS);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    asm_q, asm_d;
  logic             err_to_q, err_to_d;
  logic             err_of_q, err_of_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [AW-1:0]    palabra_nueva;
  logic             push;
  logic             pop;
  logic             acepta;
  logic             vacio;
  logic             lleno;

  assign pop    = !vacio && palabra_ready;
  assign acepta = !lleno || pop;

  // Assembled word including the byte arriving this cycle, so the last
  // byte can be pushed without an extra cycle of latency.
  always_comb begin
    palabra_nueva = asm_q;
    for (int i = 0; i < PALABRAS; i++) begin
      if (idx_q == IDX_W'(i)) palabra_nueva[8*i +: 8] = dato;
    end
  end

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    err_to_d = 1'b0;
    err_of_d = 1'b0;
    push     = 1'b0;

    unique case (estado_q)
      IDLE: begin
        if (rx_flat && (dato == SYNC_BYTE)) begin
          estado_d = CARGA;
          idx_d    = '0;
          timer_d  = '0;
        end
      end
      CARGA: begin
        if (rx_flat) begin
          asm_d   = palabra_nueva;
          timer_d = '0;
          if (idx_q == IDX_W'(PALABRAS - 1)) begin
            push     = 1'b1;
            estado_d = IDLE;
            idx_d    = '0;
            if (acepta) cnt_d    = cnt_q + 16'd1;
            else        err_of_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
          estado_d = IDLE;
          idx_d    = '0;
          timer_d  = '0;
          err_to_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      asm_q    <= '0;
      cnt_q    <= 16'd0;
      err_to_q <= 1'b0;
      err_of_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
      err_of_q <= err_of_d;
    end
  end

  fifo_palabras #(
    .ANCHO (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .dato_in  (palabra_nueva),
    .pop      (palabra_ready),
    .dato_out (palabra),
    .vacio    (vacio),
    .lleno    (lleno)
  );

  assign palabra_valid = !vacio;
  assign ocupado       = (estado_q == CARGA);
  assign err_timeout   = err_to_q;
  assign err_overflow  = err_of_q;
  assign cnt_tramas    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_control_palabras.sv
// Directed bench for control_palabras: frame table plus hand-written
// timeout, overflow, simultaneous push/pop and reset sequences.
`default_nettype none

module tb_control_palabras;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  dato;
  logic        rx_flat;
  logic [63:0] palabra;
  logic        palabra_valid;
  logic        palabra_ready;
  logic        ocupado;
  logic        err_timeout;
  logic        err_overflow;
  logic [15:0] cnt_tramas;

  int n_cmp = 0;
  int n_mis = 0;
  int n_to  = 0;
  int n_of  = 0;

  control_palabras #(
    .PALABRAS       (8),
    .TIMEOUT_CICLOS (T),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dato          (dato),
    .rx_flat       (rx_flat),
    .palabra       (palabra),
    .palabra_valid (palabra_valid),
    .palabra_ready (palabra_ready),
    .ocupado       (ocupado),
    .err_timeout   (err_timeout),
    .err_overflow  (err_overflow),
    .cnt_tramas    (cnt_tramas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_timeout)  n_to++;
    if (err_overflow) n_of++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  ruido;
    logic [63:0] seq;       // bytes in send order, first byte in the MSBs
    int          gap;
    logic [63:0] esperado;
  } vec_t;

  vec_t tabla [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nom, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nom, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    dato    = b;
    rx_flat = 1'b1;
    step();
    rx_flat = 1'b0;
  endtask

  // Sends sync plus 8 bytes; returns right after the last byte's edge.
  task automatic send_frame(input logic [63:0] seq, input int gap, input logic last_ready);
    logic [63:0] s;
    s = seq;
    send_byte(8'hA5);
    chk("ocupado_tras_sync", {63'd0, ocupado}, 64'd1);
    repeat (gap) step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) palabra_ready = last_ready;
      send_byte(s[63-8*i -: 8]);
      if (i < 7) repeat (gap) step();
    end
  endtask

  task automatic chk_reset_outs(input string nom);
    chk({nom, "_palabra"}, palabra, 64'd0);
    chk({nom, "_valid"}, {63'd0, palabra_valid}, 64'd0);
    chk({nom, "_ocupado"}, {63'd0, ocupado}, 64'd0);
    chk({nom, "_errs"}, {62'd0, err_timeout, err_overflow}, 64'd0);
    chk({nom, "_cnt"}, {48'd0, cnt_tramas}, 64'd0);
  endtask

  initial begin
    int exp_cnt;

    tabla[0] = '{8'h00, 64'h0102030405060708, 3, 64'h0807060504030201};
    tabla[1] = '{8'h3C, 64'h1111111111111111, 0, 64'h1111111111111111};
    tabla[2] = '{8'hFF, 64'hA5A500FF12345678, 1, 64'h78563412FF00A5A5};
    tabla[3] = '{8'h3C, 64'hDEADBEEF00010203, 0, 64'h03020100EFBEADDE};

    rst           = 1'b0;
    dato          = 8'h00;
    rx_flat       = 1'b0;
    palabra_ready = 1'b1;
    repeat (2) step();
    chk_reset_outs("reset_held");
    rst = 1'b1;
    step();
    chk_reset_outs("reset_released");

    // Noise in IDLE must be ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    chk("ruido_ocupado", {63'd0, ocupado}, 64'd0);

    exp_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      send_byte(tabla[k].ruido);
      chk($sformatf("v%0d_ruido_ocupado", k), {63'd0, ocupado}, 64'd0);
      send_frame(tabla[k].seq, tabla[k].gap, 1'b1);
      exp_cnt++;
      chk($sformatf("v%0d_valid", k), {63'd0, palabra_valid}, 64'd1);
      chk($sformatf("v%0d_palabra", k), palabra, tabla[k].esperado);
      chk($sformatf("v%0d_cnt", k), {48'd0, cnt_tramas}, 64'(exp_cnt));
      chk($sformatf("v%0d_ocupado_fin", k), {63'd0, ocupado}, 64'd0);
      step();
      chk($sformatf("v%0d_valid_baja", k), {63'd0, palabra_valid}, 64'd0);
    end
    chk("sin_errores_tabla", 64'(n_to + n_of), 64'd0);

    // Timeout: sync, 3 bytes, then silence.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (T - 1) step();
    chk("to_antes_ocupado", {63'd0, ocupado}, 64'd1);
    chk("to_antes_err", {63'd0, err_timeout}, 64'd0);
    step();
    chk("to_pulso", {63'd0, err_timeout}, 64'd1);
    chk("to_ocupado", {63'd0, ocupado}, 64'd0);
    step();
    chk("to_pulso_fin", {63'd0, err_timeout}, 64'd0);
    chk("to_sin_palabra", {63'd0, palabra_valid}, 64'd0);
    chk("to_pulsos", 64'(n_to), 64'd1);
    send_frame(64'h5555AAAA5555AAAA, 0, 1'b1);
    chk("to_sig_palabra", palabra, 64'hAAAA5555AAAA5555);
    chk("to_sig_cnt", {48'd0, cnt_tramas}, 64'd5);
    step();

    // Overflow with ready low; frames back to back.
    rst = 1'b0;
    step();
    rst = 1'b1;
    palabra_ready = 1'b0;
    send_frame(64'hA1A2A3A4A5A6A7A8, 0, 1'b0);
    chk("of_w1_valid", {63'd0, palabra_valid}, 64'd1);
    send_frame(64'h0011223344556677, 0, 1'b0);
    send_frame(64'hFFEEDDCCBBAA9988, 0, 1'b0);
    chk("of_pulso", {63'd0, err_overflow}, 64'd1);
    chk("of_cnt", {48'd0, cnt_tramas}, 64'd2);
    chk("of_cabeza", palabra, 64'hA8A7A6A5A4A3A2A1);
    step();
    chk("of_pulso_fin", {63'd0, err_overflow}, 64'd0);
    chk("of_cabeza_estable", palabra, 64'hA8A7A6A5A4A3A2A1);
    palabra_ready = 1'b1;
    step();
    chk("of_w2", palabra, 64'h7766554433221100);
    palabra_ready = 1'b0;

    // Fill to two entries, then last byte coincides with a pop.
    send_frame(64'h1020304050607080, 0, 1'b0);
    chk("full_cnt", {48'd0, cnt_tramas}, 64'd3);
    chk("full_cabeza", palabra, 64'h7766554433221100);
    send_frame(64'h0F1E2D3C4B5A6978, 0, 1'b1);
    chk("simul_sin_of", {63'd0, err_overflow}, 64'd0);
    chk("simul_cabeza", palabra, 64'h8070605040302010);
    chk("simul_cnt", {48'd0, cnt_tramas}, 64'd4);
    step();
    chk("simul_w5", palabra, 64'h78695A4B3C2D1E0F);
    chk("simul_w5_valid", {63'd0, palabra_valid}, 64'd1);
    step();
    chk("vacio_valid", {63'd0, palabra_valid}, 64'd0);
    chk("vacio_mantiene", palabra, 64'h78695A4B3C2D1E0F);
    chk("of_pulsos", 64'(n_of), 64'd1);

    // Reset mid-frame with one word buffered.
    palabra_ready = 1'b0;
    send_frame(64'h0102030405060708, 0, 1'b0);
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
    chk("pre_rst_ocupado", {63'd0, ocupado}, 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_outs("rst_async");
    step();
    chk_reset_outs("rst_bajo");
    rst = 1'b1;
    palabra_ready = 1'b1;
    step();
    send_frame(64'hCAFEBABE12345678, 0, 1'b1);
    chk("post_rst_palabra", palabra, 64'h78563412BEBAFECA);
    chk("post_rst_cnt", {48'd0, cnt_tramas}, 64'd1);
    step();
    chk("post_rst_solo_una", {63'd0, palabra_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
